// File: rtl/mem_pkg.sv
// Shared types and defaults for the multi-cycle SRAM memory stage.
// No logic; no latency; no backpressure.
// Holds the FSM state encoding and a width helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SRAM_DW     = 16;
    localparam int DEF_SRAM_AW     = 18;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_BEATS       = DEF_DATA_W / DEF_SRAM_DW;
    localparam int WAIT_W          = 4;

    // Counter widths must stay at least one bit even when only one value exists.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Nested wait/beat counter that paces each SRAM beat of an access.
// Latency: flags are combinational from the registered counts; advances one step per enabled cycle.
// Backpressure: none; held at zero while clr is high.
module mem_beat_counter
    import mem_pkg::*;
#(
    parameter int BEATS       = DEF_BEATS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    localparam int BEAT_W     = clog2_min1(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [BEAT_W-1:0] beat,
    output logic              last_cycle,
    output logic              last_beat
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_CYCLES);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BEATS - 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign last_cycle = (wait_cnt == WAIT_MAX);
    assign last_beat  = (beat == BEAT_MAX);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wait_cnt <= '0;
            beat     <= '0;
        end else if (en) begin
            if (last_cycle) begin
                wait_cnt <= '0;
                beat     <= last_beat ? '0 : beat + 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_mem_stage.sv
// Pipeline memory stage doing loads/stores as little-endian beats on a narrow wait-stated SRAM.
// Latency: BEATS*(WAIT_CYCLES+1) access cycles after the accept cycle, then one DONE cycle.
// Backpressure: ready drops in the accept cycle and stays low until DONE; freeze = ~ready.
module sram_mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SRAM_DW     = DEF_SRAM_DW,
    parameter int SRAM_AW     = DEF_SRAM_AW,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [DATA_W-1:0]  alu_res,
    input  logic [DATA_W-1:0]  val_rm,
    output logic [DATA_W-1:0]  rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    input  logic [SRAM_DW-1:0] sram_dq_in
);

    localparam int BEATS   = DATA_W / SRAM_DW;
    localparam int BEAT_W  = clog2_min1(BEATS);
    localparam int BEAT_SH = $clog2(BEATS);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int WA_W    = DATA_W - BYTE_SH;
    localparam int FULL_W  = WA_W + BEAT_W + SRAM_AW;

    mem_state_t         state;
    logic               op_we;
    logic [WA_W-1:0]    word_addr;
    logic [DATA_W-1:0]  wdata;
    logic [BEAT_W-1:0]  beat;
    logic               last_cycle;
    logic               last_beat;
    logic               in_access;
    logic               store_beat;
    logic [FULL_W-1:0]  full_addr;
    logic               unused_bits;

    mem_beat_counter #(
        .BEATS       (BEATS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_beat_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (!in_access),
        .en         (in_access),
        .beat       (beat),
        .last_cycle (last_cycle),
        .last_beat  (last_beat)
    );

    assign in_access  = (state == ACCESS);
    assign store_beat = in_access && op_we;

    // Bus is a pure decode of registered state so it is glitch-free and idle outside ACCESS.
    assign full_addr   = (FULL_W'(word_addr) << BEAT_SH) | FULL_W'(beat);
    assign sram_addr   = in_access ? full_addr[SRAM_AW-1:0] : '0;
    assign sram_dq_out = store_beat ? wdata[int'(beat)*SRAM_DW +: SRAM_DW] : '0;
    assign sram_dq_oe  = store_beat;
    // Releasing the strobe one cycle early gives address/data hold past the write edge.
    assign sram_we_n   = !(store_beat && (WAIT_CYCLES == 0 || !last_cycle));

    assign ready = (state == DONE) || (state == IDLE && !mem_r_en && !mem_w_en);

    assign unused_bits = ^{alu_res[BYTE_SH-1:0], full_addr[FULL_W-1:SRAM_AW]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            word_addr <= '0;
            wdata     <= '0;
            rd_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_r_en || mem_w_en) begin
                        state     <= ACCESS;
                        op_we     <= mem_w_en;
                        word_addr <= alu_res[DATA_W-1:BYTE_SH];
                        wdata     <= val_rm;
                    end
                end
                ACCESS: begin
                    if (!op_we && last_cycle) begin
                        rd_data[int'(beat)*SRAM_DW +: SRAM_DW] <= sram_dq_in;
                    end
                    if (last_cycle && last_beat) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench: four stage configurations, each with its own beat-level SRAM; word-level reference model.
module tb_sram_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en   [4];
    logic        w_en   [4];
    logic [31:0] alu    [4];
    logic [31:0] val    [4];
    logic [31:0] rd     [4];
    logic        rdy    [4];
    logic [17:0] addr   [4];
    logic [15:0] dq_out [4];
    logic [15:0] dq_in  [4];
    logic        oe     [4];
    logic        we_n   [4];
    logic [7:0]  dq_out8;

    logic [15:0] smem   [4][1024];
    logic [31:0] rmem   [4][64];
    logic [31:0] ref_rd [4];

    logic [17:0] q_a0[$];
    logic [15:0] q_d0[$];
    logic        q_w0[$];
    logic [17:0] q_a2[$];
    logic [7:0]  q_d2[$];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          d;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] v;
        int          low;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    sram_mem_stage #(.DATA_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]), .alu_res(alu[0]),
        .val_rm(val[0]), .rd_data(rd[0]), .ready(rdy[0]), .sram_addr(addr[0]),
        .sram_dq_out(dq_out[0]), .sram_dq_oe(oe[0]), .sram_we_n(we_n[0]), .sram_dq_in(dq_in[0]));

    sram_mem_stage #(.DATA_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]), .alu_res(alu[1]),
        .val_rm(val[1]), .rd_data(rd[1]), .ready(rdy[1]), .sram_addr(addr[1]),
        .sram_dq_out(dq_out[1]), .sram_dq_oe(oe[1]), .sram_we_n(we_n[1]), .sram_dq_in(dq_in[1]));

    sram_mem_stage #(.DATA_W(32), .SRAM_DW(8), .SRAM_AW(18), .WAIT_CYCLES(0)) u_dut_b4 (
        .clk(clk), .rst(rst), .mem_r_en(r_en[2]), .mem_w_en(w_en[2]), .alu_res(alu[2]),
        .val_rm(val[2]), .rd_data(rd[2]), .ready(rdy[2]), .sram_addr(addr[2]),
        .sram_dq_out(dq_out8), .sram_dq_oe(oe[2]), .sram_we_n(we_n[2]), .sram_dq_in(dq_in[2][7:0]));

    sram_mem_stage #(.DATA_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .mem_r_en(r_en[3]), .mem_w_en(w_en[3]), .alu_res(alu[3]),
        .val_rm(val[3]), .rd_data(rd[3]), .ready(rdy[3]), .sram_addr(addr[3]),
        .sram_dq_out(dq_out[3]), .sram_dq_oe(oe[3]), .sram_we_n(we_n[3]), .sram_dq_in(dq_in[3]));

    assign dq_out[2] = {8'h00, dq_out8};

    // Beat-level SRAM: write on any clock edge with strobe low, read data presented before the edge.
    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (oe[d] && !we_n[d]) smem[d][addr[d][9:0]] <= dq_out[d];
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) dq_in[d] <= smem[d][addr[d][9:0]];
        if (oe[0]) begin
            q_a0.push_back(addr[0]);
            q_d0.push_back(dq_out[0]);
            q_w0.push_back(we_n[0]);
        end
        if (oe[2]) begin
            q_a2.push_back(addr[2]);
            q_d2.push_back(dq_out8);
        end
    end

    function automatic int beats_of(input int d);
        return (d == 2) ? 4 : 2;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: stall length from beat count and wait states; memory kept as whole words.
    function void model_step(input int d, input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] v, output int exp_low, output logic [31:0] exp_rd);
        int wa;
        wa = int'(a[7:2]);
        exp_low = (r || w) ? beats_of(d) * (wait_of(d) + 1) : 0;
        if (w) rmem[d][wa] = v;
        else if (r) ref_rd[d] = rmem[d][wa];
        exp_rd = ref_rd[d];
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after DONE (or after the ALU cycle).
    task automatic do_op(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] v, output logic first_rdy, output int lowc,
                         output logic [31:0] rdv);
        r_en[d] = r; w_en[d] = w; alu[d] = a; val[d] = v;
        lowc = 0;
        #1;
        first_rdy = rdy[d];
        if (!first_rdy) begin
            @(negedge clk);
            for (int c = 0; c < 100; c++) begin
                #1;
                if (rdy[d]) break;
                lowc++;
                @(negedge clk);
            end
        end
        rdv = rd[d];
        @(negedge clk);
        r_en[d] = 1'b0; w_en[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] v, input int exp_low, input logic [31:0] exp_rd,
                          input string tag);
        logic        fr;
        int          lc;
        logic [31:0] rv;
        do_op(d, r, w, a, v, fr, lc, rv);
        chk({tag, "_accept_ready"}, {31'd0, fr}, (r || w) ? 32'd0 : 32'd1);
        chk({tag, "_stall_cycles"}, lc, exp_low);
        chk({tag, "_rd_data"}, rv, exp_rd);
    endtask

    task automatic step(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] v, input string tag);
        int          el;
        logic [31:0] er;
        model_step(d, r, w, a, v, el, er);
        run_op(d, r, w, a, v, el, er, tag);
    endtask

    initial begin
        int          el;
        logic [31:0] er;
        logic [17:0] ea;

        tbl[0]  = '{0, 1'b1, 1'b0, 32'h10,  32'h0,        4, 32'hDEADBEEF};
        tbl[1]  = '{0, 1'b0, 1'b0, 32'h123, 32'h0,        0, 32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 1'b1, 32'h20,  32'h12345678, 4, 32'hDEADBEEF};
        tbl[3]  = '{0, 1'b1, 1'b0, 32'h23,  32'h0,        4, 32'h12345678};
        tbl[4]  = '{0, 1'b0, 1'b1, 32'h10,  32'h55AA00FF, 4, 32'h12345678};
        tbl[5]  = '{0, 1'b1, 1'b0, 32'h10,  32'h0,        4, 32'h55AA00FF};
        tbl[6]  = '{1, 1'b0, 1'b1, 32'h08,  32'hCAFEF00D, 8, 32'h0};
        tbl[7]  = '{1, 1'b1, 1'b0, 32'h08,  32'h0,        8, 32'hCAFEF00D};
        tbl[8]  = '{2, 1'b1, 1'b0, 32'h0C,  32'h0,        4, 32'hA1B2C3D4};
        tbl[9]  = '{2, 1'b0, 1'b0, 32'h0,   32'h0,        0, 32'hA1B2C3D4};
        tbl[10] = '{3, 1'b0, 1'b1, 32'h04,  32'h0BADF00D, 2, 32'h0};
        tbl[11] = '{3, 1'b1, 1'b0, 32'h04,  32'h0,        2, 32'h0BADF00D};

        for (int d = 0; d < 4; d++) begin
            r_en[d] = 1'b0; w_en[d] = 1'b0; alu[d] = '0; val[d] = '0; ref_rd[d] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", {31'd0, rdy[0]}, 32'd1);
        chk("reset_rd_data", rd[0], 32'd0);
        chk("reset_we_n", {31'd0, we_n[0]}, 32'd1);
        chk("reset_oe", {31'd0, oe[0]}, 32'd0);
        chk("reset_sram_addr", {14'd0, addr[0]}, 32'd0);
        chk("reset_dq_out", {16'd0, dq_out[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Default store: two beats at word 4, strobe low on the first cycle of each beat.
        q_a0.delete(); q_d0.delete(); q_w0.delete();
        step(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store_def");
        chk("store_def_bus_cycles", q_a0.size(), 32'd4);
        for (int i = 0; i < 4 && i < q_a0.size(); i++) begin
            chk($sformatf("store_def_addr%0d", i), {14'd0, q_a0[i]}, (i < 2) ? 32'd8 : 32'd9);
            chk($sformatf("store_def_dq%0d", i), {16'd0, q_d0[i]}, (i < 2) ? 32'hBEEF : 32'hDEAD);
            chk($sformatf("store_def_we_n%0d", i), {31'd0, q_w0[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end

        // Byte-wide SRAM: four single-cycle beats at 4*wa .. 4*wa+3, low byte first.
        q_a2.delete(); q_d2.delete();
        step(2, 1'b0, 1'b1, 32'h0C, 32'hA1B2C3D4, "store_b4");
        chk("store_b4_bus_cycles", q_a2.size(), 32'd4);
        for (int i = 0; i < 4 && i < q_a2.size(); i++) begin
            er = 32'hA1B2C3D4 >> (8 * i);
            chk($sformatf("store_b4_addr%0d", i), {14'd0, q_a2[i]}, 32'd12 + 32'(i));
            chk($sformatf("store_b4_dq%0d", i), {24'd0, q_d2[i]}, {24'd0, er[7:0]});
        end

        for (int i = 0; i < 12; i++) begin
            model_step(tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].v, el, er);
            run_op(tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].v, tbl[i].low, tbl[i].rd,
                   $sformatf("vec%0d", i));
        end

        // Reset while the second beat of a load is on the bus.
        r_en[0] = 1'b1; alu[0] = 32'h20;
        repeat (3) @(negedge clk);
        chk("mid_reset_beat1_addr", {14'd0, addr[0]}, 32'd17);
        rst = 1'b0; r_en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_reset_ready", {31'd0, rdy[0]}, 32'd1);
        chk("mid_reset_rd_data", rd[0], 32'd0);
        chk("mid_reset_we_n", {31'd0, we_n[0]}, 32'd1);
        chk("mid_reset_oe", {31'd0, oe[0]}, 32'd0);
        chk("mid_reset_addr", {14'd0, addr[0]}, 32'd0);
        for (int d = 0; d < 4; d++) ref_rd[d] = '0;
        @(negedge clk);
        run_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 4, 32'h12345678, "post_reset_load");
        ref_rd[0] = 32'h12345678;

        for (int d = 0; d < 4; d++) begin
            for (int wa = 0; wa < 16; wa++) begin
                step(d, 1'b0, 1'b1, 32'(wa) << 2, $urandom, $sformatf("pre_d%0d_w%0d", d, wa));
            end
        end

        for (int n = 0; n < 100; n++) begin
            int          d;
            int          op;
            logic [31:0] a;
            d  = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 3));
            a  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            step(d, (op == 0 || op == 3), (op == 1 || op == 3), a, $urandom,
                 $sformatf("rand%0d_d%0d_op%0d", n, d, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
